// File: rtl/ahfp_cordic_iter.sv
// rtl/ahfp_cordic_iter.sv - iterative single-precision floating-point CORDIC engine
//
// ahfp_add_sub     : combinational IEEE-754 single adder, result = dataa + datab.
//                    Round-to-nearest-even; denormal operands and underflowing
//                    results are flushed to zero; overflow saturates to Inf.
// ahfp_cordic_iter : rotation (mode 0) / vectoring (mode 1) CORDIC that reuses one
//                    adder per coordinate for every micro-rotation.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   start, mode     : request and mode, sampled only while idle
//   x_in/y_in/z_in  : single-precision operands, captured with start
//   busy, done      : busy from acceptance to completion; done is a one-cycle pulse
//   x_out/y_out/z_out : registered results (carry the CORDIC gain), held until next done

module ahfp_add_sub (
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);
    logic        a_big, sa, sb, sticky, found, rnd;
    logic [7:0]  ea, eb, d8;
    logic [26:0] ma, mb, mb_sh, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  ex;
    logic [24:0] mr;

    always_comb begin
        // Order operands by magnitude so the aligned one is never the larger.
        a_big = dataa[30:0] >= datab[30:0];
        sa    = a_big ? dataa[31] : datab[31];
        sb    = a_big ? datab[31] : dataa[31];
        ea    = a_big ? dataa[30:23] : datab[30:23];
        eb    = a_big ? datab[30:23] : dataa[30:23];
        ma    = (ea == 8'd0) ? 27'd0 : {1'b1, (a_big ? dataa[22:0] : datab[22:0]), 3'b000};
        mb    = (eb == 8'd0) ? 27'd0 : {1'b1, (a_big ? datab[22:0] : dataa[22:0]), 3'b000};
        d8    = ea - eb;

        // Alignment keeps guard/round bits plus a sticky OR of everything shifted out.
        if (d8 > 8'd26) begin
            mb_sh  = 27'd0;
            sticky = |mb;
        end else begin
            mb_sh  = mb >> d8;
            sticky = |(mb & ~(27'h7FFFFFF << d8));
        end
        mb_sh[0] = mb_sh[0] | sticky;

        sum = (sa ^ sb) ? ({1'b0, ma} - {1'b0, mb_sh}) : ({1'b0, ma} + {1'b0, mb_sh});

        lz    = 5'd0;
        found = 1'b0;
        for (int k = 26; k >= 0; k--) begin
            if (!found) begin
                if (sum[k]) found = 1'b1;
                else        lz    = lz + 5'd1;
            end
        end

        ex = {2'b00, ea};
        if (sum[27]) begin
            norm = sum[27:1] | {26'd0, sum[0]};
            ex   = ex + 10'd1;
        end else begin
            norm = sum[26:0] << lz;
            ex   = ex - {5'd0, lz};
        end

        rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
        mr  = {1'b0, norm[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            ex = ex + 10'd1;
        end

        // A clear hidden bit only happens for an exactly-zero sum: return +0.
        if (!mr[23])
            result = 32'd0;
        else if (ex[9] || (ex == 10'd0))
            result = {sa, 31'd0};
        else if (ex[8:0] >= 9'd255)
            result = {sa, 8'hFF, 23'd0};
        else
            result = {sa, ex[7:0], mr[22:0]};
    end
endmodule

module ahfp_cordic_iter #(
    parameter int N         = 10,
    parameter int QUAD_CORR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

    localparam logic [31:0] HALF_PI = 32'h3FC90FDB;
    localparam logic [3:0]  I_LAST  = 4'(N - 1);

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [31:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
    logic        mode_q, mode_d;
    logic [3:0]  i_q, i_d;

    logic [31:0] x_sh, y_sh, x_b, y_b, z_b, x_sum, y_sum, z_sum;
    logic [30:0] atan_mag;
    logic        dir, rot_ccw, rot_cw;

    // Multiply by 2^-sh via the exponent; anything that would reach exponent 0
    // (including zero and denormal operands) becomes +0 instead of wrapping.
    function automatic logic [31:0] scale(input logic [31:0] v, input logic [3:0] sh);
        if (v[30:23] <= {4'd0, sh})
            return 32'd0;
        return {v[31], v[30:23] - {4'd0, sh}, v[22:0]};
    endfunction

    always_comb begin
        case (i_q)
            4'd0:    atan_mag = 31'h3F490FDB;
            4'd1:    atan_mag = 31'h3EED6338;
            4'd2:    atan_mag = 31'h3E7ADBB0;
            4'd3:    atan_mag = 31'h3DFEADD5;
            4'd4:    atan_mag = 31'h3D7FAADE;
            4'd5:    atan_mag = 31'h3CFFEAAE;
            4'd6:    atan_mag = 31'h3C7FFAAB;
            4'd7:    atan_mag = 31'h3BFFFEAB;
            4'd8:    atan_mag = 31'h3B7FFFAB;
            4'd9:    atan_mag = 31'h3AFFFFEB;
            4'd10:   atan_mag = 31'h3A7FFFFB;
            4'd11:   atan_mag = 31'h39FFFFFF;
            default: atan_mag = {8'd127 - {4'd0, i_q}, 23'd0};
        endcase
    end

    // ccw: (x,y,z) <- (-y, x, z - pi/2); cw: (x,y,z) <- (y, -x, z + pi/2).
    always_comb begin
        rot_ccw = 1'b0;
        rot_cw  = 1'b0;
        if (QUAD_CORR != 0) begin
            if (!mode_q) begin
                rot_ccw = !z_q[31] && (z_q[30:0] > HALF_PI[30:0]);
                rot_cw  =  z_q[31] && (z_q[30:0] > HALF_PI[30:0]);
            end else begin
                rot_cw  = x_q[31] && !y_q[31];
                rot_ccw = x_q[31] &&  y_q[31];
            end
        end
    end

    assign dir  = mode_q ? y_q[31] : ~z_q[31];
    assign x_sh = scale(x_q, i_q);
    assign y_sh = scale(y_q, i_q);
    assign x_b  = dir ? {~y_sh[31], y_sh[30:0]} : y_sh;
    assign y_b  = dir ? x_sh : {~x_sh[31], x_sh[30:0]};
    // During PRE the z adder applies the quadrant offset rather than an atan step.
    assign z_b  = (state_q == S_PRE) ? {rot_ccw, HALF_PI[30:0]} : {dir, atan_mag};

    ahfp_add_sub u_add_x (.dataa(x_q), .datab(x_b), .result(x_sum));
    ahfp_add_sub u_add_y (.dataa(y_q), .datab(y_b), .result(y_sum));
    ahfp_add_sub u_add_z (.dataa(z_q), .datab(z_b), .result(z_sum));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            z_q     <= 32'd0;
            xo_q    <= 32'd0;
            yo_q    <= 32'd0;
            zo_q    <= 32'd0;
            mode_q  <= 1'b0;
            i_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
            mode_q  <= mode_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PRE;
            S_PRE:   state_d = S_ITER;
            S_ITER:  if (i_q == I_LAST) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        xo_d   = xo_q;
        yo_d   = yo_q;
        zo_d   = zo_q;
        mode_d = mode_q;
        i_d    = i_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d    = x_in;
                    y_d    = y_in;
                    z_d    = z_in;
                    mode_d = mode;
                end
            end
            S_PRE: begin
                if (rot_ccw) begin
                    x_d = {~y_q[31], y_q[30:0]};
                    y_d = x_q;
                    z_d = z_sum;
                end else if (rot_cw) begin
                    x_d = y_q;
                    y_d = {~x_q[31], x_q[30:0]};
                    z_d = z_sum;
                end
                i_d = 4'd0;
            end
            S_ITER: begin
                x_d = x_sum;
                y_d = y_sum;
                z_d = z_sum;
                i_d = i_q + 4'd1;
                if (i_q == I_LAST) begin
                    xo_d = x_sum;
                    yo_d = y_sum;
                    zo_d = z_sum;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
        x_out = xo_q;
        y_out = yo_q;
        z_out = zo_q;
    end
endmodule
